// File: rtl/tr_stepper_regulator.sv
// rtl/tr_stepper_regulator.sv - hysteresis position regulator driving a stepper motor
//
// Samples an unsigned ADC value, compares it against a setpoint with a start/stop
// hysteresis window and drives a stepper driver (enable, step, direction). The
// FSM is evaluated once per captured sample; a direction change always passes
// through SETUP so drv_dir is stable for DIR_SETUP cycles before the next step.
//
// Ports:
//   clk        in   system clock (50 MHz), rising edge
//   rst        in   synchronous reset, active-high
//   x          in   ADC sample, unsigned, W bits
//   data_valid in   x valid strobe (ignored while enable=0)
//   enable     in   regulation permit; 0 forces the motor off
//   x0         in   setpoint, unsigned
//   dx1        in   inner (stop) threshold
//   dx2        in   outer (start) threshold, dx1 <= dx2
//   drv_SM     out  driver enable (SETUP or RUN)
//   drv_step   out  step pulse, STEP_WIDTH cycles every STEP_DIV cycles in RUN
//   drv_dir    out  1 = sample above setpoint, 0 = below
module tr_stepper_regulator #(
  parameter int W          = 12,
  parameter int STEP_DIV   = 1000,
  parameter int STEP_WIDTH = 1,
  parameter int DIR_SETUP  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic         data_valid,
  input  logic         enable,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] dx1,
  input  logic [W-1:0] dx2,
  output logic         drv_SM,
  output logic         drv_step,
  output logic         drv_dir
);

  localparam int SCW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int UCW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [SCW-1:0] STEP_LAST  = SCW'(STEP_DIV - 1);
  localparam logic [SCW-1:0] STEP_HIGH  = SCW'(STEP_WIDTH);
  localparam logic [UCW-1:0] SETUP_LAST = UCW'(DIR_SETUP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   xs;
  logic           sample_done;
  logic [SCW-1:0] step_cnt, step_cnt_n;
  logic [UCW-1:0] setup_cnt, setup_cnt_n;
  logic           dir_n, sm_n, step_n;

  // |xs - x0| and the sign of the error, computed without a widened signed
  // subtract: the larger operand minus the smaller always fits in W bits.
  logic [W-1:0] mag;
  logic         err_pos;
  logic         stop_req, start_req, rev_req;

  always_comb begin
    err_pos   = (xs > x0);
    mag       = err_pos ? (xs - x0) : (x0 - xs);
    stop_req  = (mag <= dx1);
    start_req = (mag > dx2);
    // A reversal needs a nonzero error, which !stop_req guarantees even with dx1 = 0.
    rev_req   = !stop_req && (err_pos != drv_dir);
  end

  always_comb begin
    state_n     = state;
    step_cnt_n  = step_cnt;
    setup_cnt_n = setup_cnt;
    dir_n       = drv_dir;

    case (state)
      IDLE: begin
        if (sample_done && start_req) begin
          state_n     = SETUP;
          setup_cnt_n = '0;
          dir_n       = err_pos;
        end
      end
      SETUP: begin
        if (sample_done && stop_req) begin
          state_n = IDLE;
        end else if (sample_done && rev_req) begin
          setup_cnt_n = '0;
          dir_n       = err_pos;
        end else if (setup_cnt == SETUP_LAST) begin
          state_n    = RUN;
          step_cnt_n = '0;
        end else begin
          setup_cnt_n = setup_cnt + 1'b1;
        end
      end
      RUN: begin
        if (sample_done && stop_req) begin
          state_n = IDLE;
        end else if (sample_done && rev_req) begin
          state_n     = SETUP;
          setup_cnt_n = '0;
          dir_n       = err_pos;
        end else begin
          step_cnt_n = (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Losing the permit wins over any sample; direction is deliberately kept.
    if (!enable) begin
      state_n = IDLE;
      dir_n   = drv_dir;
    end

    if (state_n == IDLE) begin
      step_cnt_n  = '0;
      setup_cnt_n = '0;
    end

    // Outputs are registered from next-state values so they align with the state.
    sm_n   = (state_n != IDLE);
    step_n = (state_n == RUN) && (step_cnt_n < STEP_HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs          <= '0;
      sample_done <= 1'b0;
      state       <= IDLE;
      step_cnt    <= '0;
      setup_cnt   <= '0;
      drv_SM      <= 1'b0;
      drv_step    <= 1'b0;
      drv_dir     <= 1'b0;
    end else begin
      if (data_valid && enable) begin
        xs <= x;
      end
      sample_done <= data_valid && enable;
      state       <= state_n;
      step_cnt    <= step_cnt_n;
      setup_cnt   <= setup_cnt_n;
      drv_SM      <= sm_n;
      drv_step    <= step_n;
      drv_dir     <= dir_n;
    end
  end

endmodule

// File: tb/tb_tr_stepper_regulator.sv
// tb/tb_tr_stepper_regulator.sv - self-checking bench for tr_stepper_regulator
module tb_tr_stepper_regulator;

  localparam int W          = 12;
  localparam int STEP_DIV   = 1000;
  localparam int STEP_WIDTH = 1;
  localparam int DIR_SETUP  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         data_valid = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] x   = '0;
  logic [W-1:0] x0  = 12'd5;
  logic [W-1:0] dx1 = 12'd5;
  logic [W-1:0] dx2 = 12'd10;
  logic         drv_SM, drv_step, drv_dir;

  int n_checks = 0;
  int n_fail   = 0;
  int phase    = 0;

  tr_stepper_regulator #(
    .W(W), .STEP_DIV(STEP_DIV), .STEP_WIDTH(STEP_WIDTH), .DIR_SETUP(DIR_SETUP)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .data_valid(data_valid), .enable(enable),
    .x0(x0), .dx1(dx1), .dx2(dx2),
    .drv_SM(drv_SM), .drv_step(drv_step), .drv_dir(drv_dir)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode plus the timestamps at which SETUP and RUN were
  // entered; step and setup timing follow from elapsed cycles.
  int m_cyc     = 0;
  int m_mode    = 0;   // 0 off, 1 direction setup, 2 stepping
  int m_t_setup = 0;
  int m_t_run   = 0;
  int m_xs      = 0;
  bit m_dir     = 1'b0;
  bit m_pending = 1'b0;
  bit m_live    = 1'b0;
  bit e_sm, e_step, e_dir;

  always @(posedge clk) begin : model
    int e;
    int mag;
    bit moved;
    m_cyc++;
    if (rst) begin
      m_mode = 0; m_dir = 1'b0; m_xs = 0; m_pending = 1'b0; m_live = 1'b1;
    end else if (!enable) begin
      m_mode = 0; m_pending = 1'b0;
    end else begin
      moved = 1'b0;
      e   = m_xs - int'(x0);
      mag = (e < 0) ? -e : e;
      if (m_pending) begin
        if (m_mode == 0) begin
          if (mag > int'(dx2)) begin
            m_mode = 1; m_t_setup = m_cyc; m_dir = (e > 0); moved = 1'b1;
          end
        end else if (mag <= int'(dx1)) begin
          m_mode = 0; moved = 1'b1;
        end else if ((e > 0) != m_dir) begin
          m_mode = 1; m_t_setup = m_cyc; m_dir = (e > 0); moved = 1'b1;
        end
      end
      if (!moved && m_mode == 1 && (m_cyc - m_t_setup) == DIR_SETUP) begin
        m_mode = 2; m_t_run = m_cyc;
      end
      m_pending = data_valid;
      if (data_valid) m_xs = int'(x);
    end
    e_sm   = (m_mode != 0);
    e_step = (m_mode == 2) && (((m_cyc - m_t_run) % STEP_DIV) < STEP_WIDTH);
    e_dir  = m_dir;
    #1;
    if (m_live) begin
      check("cyc.drv_SM",   int'(drv_SM),   int'(e_sm));
      check("cyc.drv_step", int'(drv_step), int'(e_step));
      check("cyc.drv_dir",  int'(drv_dir),  int'(e_dir));
    end
  end

  // Literal expectations, applied to both the DUT and the model; -1 = don't care.
  task automatic lit(input string name, input int sm, input int st, input int dr);
    if (sm >= 0) begin
      check({name, ".sm"}, int'(drv_SM), sm);
      check({name, ".model_sm"}, int'(e_sm), sm);
    end
    if (st >= 0) begin
      check({name, ".step"}, int'(drv_step), st);
      check({name, ".model_step"}, int'(e_step), st);
    end
    if (dr >= 0) begin
      check({name, ".dir"}, int'(drv_dir), dr);
      check({name, ".model_dir"}, int'(e_dir), dr);
    end
  endtask

  // Free running with a sample every 5th cycle; the last cycle never strobes.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid = (i < n - 1) && (phase % 5 == 0);
      phase++;
    end
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
    end
  endtask

  // Single sample; returns just after the evaluation edge.
  task automatic strobe(input int xv);
    @(negedge clk);
    x = W'(xv);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // reset, then permit low
    enable = 1'b1;
    x = 12'd25;
    repeat (5) @(negedge clk);
    lit("reset", 0, 0, 0);
    rst = 1'b0;
    enable = 1'b0;
    x = 12'd4000;
    cycles(20);
    lit("enable_low_big", 0, 0, 0);
    x = 12'd25;
    cycles(10);
    lit("enable_low_25", 0, 0, 0);

    // start above setpoint, exact latency and step period
    enable = 1'b1;
    @(negedge clk);
    x = 12'd25;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    lit("after_capture", 0, 0, 0);
    @(negedge clk);
    lit("after_eval", 1, 0, 1);
    repeat (3) @(negedge clk);
    lit("setup_last", 1, 0, 1);
    @(negedge clk);
    lit("first_step", 1, 1, 1);
    @(negedge clk);
    lit("step_width", 1, 0, 1);
    cycles(998);
    lit("before_second", 1, 0, 1);
    cycles(1);
    lit("second_step", 1, 1, 1);

    // ramp inside hysteresis band, then stop at mag == dx1
    for (int v = 25; v >= 12; v--) begin
      x = W'(v);
      cycles(6);
    end
    lit("ramp_run", 1, -1, 1);
    strobe(10);
    lit("stop_at_dx1", 0, 0, 1);

    // no start inside the band, at dx2, or at -5; start below setpoint
    strobe(13);
    quiet(3);
    lit("no_start_band", 0, 0, 1);
    strobe(15);
    lit("no_start_dx2", 0, 0, 1);
    strobe(0);
    lit("no_start_neg", 0, 0, 1);
    x0 = 12'd100;
    quiet(2);
    strobe(80);
    lit("start_below", 1, 0, 0);

    // reversals
    cycles(20);
    strobe(120);
    lit("rev_up", 1, 0, 1);
    cycles(20);
    lit("run_up", 1, -1, 1);
    strobe(80);
    lit("rev_down", 1, 0, 0);
    repeat (3) @(negedge clk);
    lit("rev_setup", 1, 0, 0);
    @(negedge clk);
    lit("rev_first_step", 1, 1, 0);

    // drop enable during a pulse
    enable = 1'b0;
    @(negedge clk);
    lit("enable_drop", 0, 0, 0);
    enable = 1'b1;
    quiet(30);
    lit("no_restart", 0, 0, 0);
    strobe(120);
    lit("restart", 1, 0, 1);
    cycles(12);

    // reset while running
    rst = 1'b1;
    @(negedge clk);
    lit("reset_run", 0, 0, 0);
    rst = 1'b0;
    quiet(20);
    lit("after_reset", 0, 0, 0);

    // stop sample aborts setup; same-direction sample does not restart it
    strobe(80);
    strobe(100);
    lit("abort_setup", 0, 0, 0);
    strobe(80);
    strobe(70);
    @(negedge clk);
    lit("setup_continue", 1, 1, 0);

    // zero error stops even with dx1 = 0
    cycles(10);
    dx1 = 12'd0;
    strobe(100);
    lit("zero_err_stop", 0, 0, 0);

    quiet(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
